// File: rtl/layer2_host_sequencer_if.sv
// Layer2 controller bus: weight/bias write port plus the sample/prediction
// handshake. The master modport is the sequencer side; slave is the Layer2 side.
interface layer2_host_sequencer_if #(
  parameter int RELU_NODES                = 4,
  parameter int LAYER_2_IN_BIT_WIDTH      = 4,
  parameter int LAYER_2_WEIGHTS_BIT_WIDTH = 4,
  parameter int RELU_INDEX_WIDTH          = 3
);

  // Write port: one-cycle enables qualify address and data.
  logic                                       weightWriteEnable;
  logic                                       biasWriteEnable;
  logic [RELU_INDEX_WIDTH-1:0]                WriteAddressSelect;
  logic [10*LAYER_2_WEIGHTS_BIT_WIDTH-1:0]    writeIn;

  // Sample/prediction exchange with the Layer2 controller.
  logic                                       inputsReady;
  logic [RELU_NODES*LAYER_2_IN_BIT_WIDTH-1:0] layer2Input;
  logic                                       inputsRecieved;
  logic                                       outputsReady;
  logic                                       outputsRecieved;
  logic [3:0]                                 predictionOutput;

  modport master (
    output weightWriteEnable,
    output biasWriteEnable,
    output WriteAddressSelect,
    output writeIn,
    output inputsReady,
    output layer2Input,
    input  inputsRecieved,
    input  outputsReady,
    output outputsRecieved,
    input  predictionOutput
  );

  modport slave (
    input  weightWriteEnable,
    input  biasWriteEnable,
    input  WriteAddressSelect,
    input  writeIn,
    input  inputsReady,
    input  layer2Input,
    output inputsRecieved,
    output outputsReady,
    input  outputsRecieved,
    output predictionOutput
  );

endinterface

// File: rtl/layer2_host_sequencer.sv
// Initiator-side driver for the Layer2 controller. Loads weight rows and the
// bias row from upstream, then runs one sample at a time through Layer2 and
// returns the 4-bit prediction upstream. A watchdog aborts a stalled exchange.
//
// Handshake semantics (cfg/sample/result): a word moves on a rising edge where
// both valid and ready are high. A source holds valid and data steady until the
// transfer; ready may be given without waiting for valid.
module layer2_host_sequencer #(
  parameter int RELU_NODES                = 4,
  parameter int LAYER_2_IN_BIT_WIDTH      = 4,
  parameter int LAYER_2_WEIGHTS_BIT_WIDTH = 4,
  parameter int RELU_INDEX_WIDTH          = 3,
  parameter int TIMEOUT_CYCLES            = 255
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       reloadRequest,
  input  logic                                       cfgValid,
  input  logic                                       cfgIsBias,
  input  logic [10*LAYER_2_WEIGHTS_BIT_WIDTH-1:0]    cfgData,
  output logic                                       cfgReady,
  input  logic                                       sampleValid,
  input  logic [RELU_NODES*LAYER_2_IN_BIT_WIDTH-1:0] sampleData,
  output logic                                       sampleReady,
  output logic                                       resultValid,
  input  logic                                       resultReady,
  output logic [3:0]                                 resultData,
  output logic                                       cfgError,
  output logic                                       timeoutError,
  output logic [2:0]                                 dbgState,
  layer2_host_sequencer_if.master                    l2
);

  localparam int CFG_W   = 10 * LAYER_2_WEIGHTS_BIT_WIDTH;
  localparam int SMP_W   = RELU_NODES * LAYER_2_IN_BIT_WIDTH;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RELU_INDEX_WIDTH-1:0] LAST_ROW = RELU_INDEX_WIDTH'(RELU_NODES - 1);
  localparam logic [WD_W-1:0]             WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    LOAD_W   = 3'd0,
    LOAD_B   = 3'd1,
    IDLE     = 3'd2,
    SEND     = 3'd3,
    WAIT_OUT = 3'd4,
    RESULT   = 3'd5
  } state_t;

  state_t state, stateNext;

  logic [RELU_INDEX_WIDTH-1:0] row, rowNext;
  logic [WD_W-1:0]             watchdog, watchdogNext, watchdogInc;

  // Registered output copies and their next values.
  logic                        cfgReadyQ, cfgReadyNext;
  logic                        sampleReadyQ, sampleReadyNext;
  logic                        resultValidQ, resultValidNext;
  logic [3:0]                  resultDataQ, resultDataNext;
  logic                        cfgErrorQ, cfgErrorNext;
  logic                        timeoutErrorQ, timeoutErrorNext;
  logic                        weightWeQ, weightWeNext;
  logic                        biasWeQ, biasWeNext;
  logic [RELU_INDEX_WIDTH-1:0] addrQ, addrNext;
  logic [CFG_W-1:0]            writeInQ, writeInNext;
  logic                        inputsReadyQ, inputsReadyNext;
  logic [SMP_W-1:0]            layer2InputQ, layer2InputNext;
  logic                        outputsRecievedQ, outputsRecievedNext;

  logic cfgFire, sampleFire, resultFire;

  // A reload request in IDLE wins over a sample offered in the same cycle,
  // so ready is withdrawn combinationally for that one cycle.
  assign sampleReady  = sampleReadyQ & ~reloadRequest;
  assign cfgReady     = cfgReadyQ;
  assign resultValid  = resultValidQ;
  assign resultData   = resultDataQ;
  assign cfgError     = cfgErrorQ;
  assign timeoutError = timeoutErrorQ;
  assign dbgState     = state;

  assign l2.weightWriteEnable  = weightWeQ;
  assign l2.biasWriteEnable    = biasWeQ;
  assign l2.WriteAddressSelect = addrQ;
  assign l2.writeIn            = writeInQ;
  assign l2.inputsReady        = inputsReadyQ;
  assign l2.layer2Input        = layer2InputQ;
  assign l2.outputsRecieved    = outputsRecievedQ;

  assign cfgFire     = cfgValid & cfgReadyQ;
  assign sampleFire  = sampleValid & sampleReady;
  assign resultFire  = resultValidQ & resultReady;
  assign watchdogInc = watchdog + 1'b1;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_W;
    else        state <= stateNext;
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row              <= '0;
      watchdog         <= '0;
      cfgReadyQ        <= 1'b0;
      sampleReadyQ     <= 1'b0;
      resultValidQ     <= 1'b0;
      resultDataQ      <= '0;
      cfgErrorQ        <= 1'b0;
      timeoutErrorQ    <= 1'b0;
      weightWeQ        <= 1'b0;
      biasWeQ          <= 1'b0;
      addrQ            <= '0;
      writeInQ         <= '0;
      inputsReadyQ     <= 1'b0;
      layer2InputQ     <= '0;
      outputsRecievedQ <= 1'b0;
    end else begin
      row              <= rowNext;
      watchdog         <= watchdogNext;
      cfgReadyQ        <= cfgReadyNext;
      sampleReadyQ     <= sampleReadyNext;
      resultValidQ     <= resultValidNext;
      resultDataQ      <= resultDataNext;
      cfgErrorQ        <= cfgErrorNext;
      timeoutErrorQ    <= timeoutErrorNext;
      weightWeQ        <= weightWeNext;
      biasWeQ          <= biasWeNext;
      addrQ            <= addrNext;
      writeInQ         <= writeInNext;
      inputsReadyQ     <= inputsReadyNext;
      layer2InputQ     <= layer2InputNext;
      outputsRecievedQ <= outputsRecievedNext;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    stateNext           = state;
    rowNext             = row;
    watchdogNext        = watchdog;
    resultValidNext     = resultValidQ;
    resultDataNext      = resultDataQ;
    cfgErrorNext        = cfgErrorQ;
    timeoutErrorNext    = timeoutErrorQ;
    weightWeNext        = 1'b0;
    biasWeNext          = 1'b0;
    addrNext            = addrQ;
    writeInNext         = writeInQ;
    inputsReadyNext     = inputsReadyQ;
    layer2InputNext     = layer2InputQ;
    outputsRecievedNext = 1'b0;

    unique case (state)
      LOAD_W: begin
        if (cfgFire) begin
          if (!cfgIsBias) begin
            weightWeNext = 1'b1;
            addrNext     = row;
            writeInNext  = cfgData;
            if (row == LAST_ROW) begin
              rowNext   = '0;
              stateNext = LOAD_B;
            end else begin
              rowNext = row + 1'b1;
            end
          end else begin
            // Wrong row type: drop the word and flag it.
            cfgErrorNext = 1'b1;
          end
        end
      end

      LOAD_B: begin
        if (cfgFire) begin
          if (cfgIsBias) begin
            biasWeNext  = 1'b1;
            addrNext    = '0;
            writeInNext = cfgData;
            stateNext   = IDLE;
          end else begin
            cfgErrorNext = 1'b1;
          end
        end
      end

      IDLE: begin
        if (reloadRequest) begin
          rowNext   = '0;
          stateNext = LOAD_W;
        end else if (sampleFire) begin
          layer2InputNext = sampleData;
          inputsReadyNext = 1'b1;
          watchdogNext    = '0;
          stateNext       = SEND;
        end
      end

      SEND: begin
        watchdogNext = watchdogInc;
        if (l2.inputsRecieved) begin
          inputsReadyNext = 1'b0;
          stateNext       = WAIT_OUT;
        end else if (watchdogInc == WD_LIMIT) begin
          timeoutErrorNext = 1'b1;
          inputsReadyNext  = 1'b0;
          stateNext        = IDLE;
        end
      end

      WAIT_OUT: begin
        watchdogNext = watchdogInc;
        if (l2.outputsReady) begin
          resultDataNext      = l2.predictionOutput;
          outputsRecievedNext = 1'b1;
          resultValidNext     = 1'b1;
          stateNext           = RESULT;
        end else if (watchdogInc == WD_LIMIT) begin
          timeoutErrorNext = 1'b1;
          inputsReadyNext  = 1'b0;
          stateNext        = IDLE;
        end
      end

      RESULT: begin
        if (resultFire) begin
          resultValidNext = 1'b0;
          stateNext       = IDLE;
        end
      end

      default: begin
        stateNext = LOAD_W;
        rowNext   = '0;
      end
    endcase

    // Upstream readiness follows the state being entered.
    cfgReadyNext    = (stateNext == LOAD_W) || (stateNext == LOAD_B);
    sampleReadyNext = (stateNext == IDLE);
  end

endmodule

// File: tb/tb_layer2_host_sequencer.sv
// Directed-plus-random bench for layer2_host_sequencer: upstream driver tasks,
// a Layer2 responder, and a write scoreboard fed by an expected-write model.
module tb_layer2_host_sequencer;

  localparam int NODES   = 4;
  localparam int IN_W    = 4;
  localparam int WT_W    = 4;
  localparam int AW      = 3;
  localparam int TIMEOUT = 255;
  localparam int CW      = 10 * WT_W;
  localparam int SW      = NODES * IN_W;
  localparam int EW      = 1 + AW + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reloadRequest = 1'b0;
  logic          cfgValid = 1'b0;
  logic          cfgIsBias = 1'b0;
  logic [CW-1:0] cfgData = '0;
  logic          cfgReady;
  logic          sampleValid = 1'b0;
  logic [SW-1:0] sampleData = '0;
  logic          sampleReady;
  logic          resultValid;
  logic          resultReady = 1'b0;
  logic [3:0]    resultData;
  logic          cfgError;
  logic          timeoutError;
  logic [2:0]    dbgState;

  layer2_host_sequencer_if #(
    .RELU_NODES(NODES), .LAYER_2_IN_BIT_WIDTH(IN_W),
    .LAYER_2_WEIGHTS_BIT_WIDTH(WT_W), .RELU_INDEX_WIDTH(AW)
  ) l2 ();

  layer2_host_sequencer #(
    .RELU_NODES(NODES), .LAYER_2_IN_BIT_WIDTH(IN_W),
    .LAYER_2_WEIGHTS_BIT_WIDTH(WT_W), .RELU_INDEX_WIDTH(AW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .reloadRequest(reloadRequest),
    .cfgValid(cfgValid), .cfgIsBias(cfgIsBias), .cfgData(cfgData), .cfgReady(cfgReady),
    .sampleValid(sampleValid), .sampleData(sampleData), .sampleReady(sampleReady),
    .resultValid(resultValid), .resultReady(resultReady), .resultData(resultData),
    .cfgError(cfgError), .timeoutError(timeoutError), .dbgState(dbgState),
    .l2(l2.master)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: record {isBias, address, data} per write-pulse cycle.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  always @(negedge clk) begin
    if (l2.weightWriteEnable || l2.biasWriteEnable)
      obs_q.push_back({l2.biasWriteEnable, l2.WriteAddressSelect, l2.writeIn});
  end

  // Reference model state: rows accepted in the current load, sticky flags.
  int   loaded = 0;
  logic expCfgErr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rnd_row();
    return CW'({$urandom(), $urandom()});
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cfgReady"}, cfgReady, 0);
    check({tag, "_sampleReady"}, sampleReady, 0);
    check({tag, "_resultValid"}, resultValid, 0);
    check({tag, "_resultData"}, resultData, 0);
    check({tag, "_cfgError"}, cfgError, 0);
    check({tag, "_timeoutError"}, timeoutError, 0);
    check({tag, "_wwe"}, l2.weightWriteEnable, 0);
    check({tag, "_bwe"}, l2.biasWriteEnable, 0);
    check({tag, "_addr"}, l2.WriteAddressSelect, 0);
    check({tag, "_writeIn"}, l2.writeIn, 0);
    check({tag, "_inputsReady"}, l2.inputsReady, 0);
    check({tag, "_layer2Input"}, l2.layer2Input, 0);
    check({tag, "_outputsRecieved"}, l2.outputsRecieved, 0);
  endtask

  // Offer one cfg word; the model decides whether it becomes a write.
  task automatic send_cfg(input logic isBias, input logic [CW-1:0] data);
    int n;
    repeat ($urandom_range(0, 1)) step();
    cfgValid = 1'b1; cfgIsBias = isBias; cfgData = data;
    n = 0;
    while (!cfgReady && n < 50) begin step(); n++; end
    check("cfg_ready_wait", cfgReady, 1);
    step();
    cfgValid = 1'b0; cfgIsBias = $urandom_range(0, 1); cfgData = rnd_row();
    if (loaded < NODES) begin
      if (!isBias) begin exp_q.push_back({1'b0, AW'(loaded), data}); loaded++; end
      else expCfgErr = 1'b1;
    end else begin
      if (isBias) begin exp_q.push_back({1'b1, AW'(0), data}); loaded = 0; end
      else expCfgErr = 1'b1;
    end
    check("cfg_error", cfgError, expCfgErr);
  endtask

  task automatic compare_writes();
    check("write_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("write_record", obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // mode 0: clean load; 1: bias offered at row 1; 2: weight offered in bias phase.
  task automatic load_all(input int mode, input logic [CW-1:0] row0);
    for (int r = 0; r < NODES; r++) begin
      if (mode == 1 && r == 1) send_cfg(1'b1, rnd_row());
      send_cfg(1'b0, (r == 0) ? row0 : rnd_row());
    end
    if (mode == 2) send_cfg(1'b0, rnd_row());
    send_cfg(1'b1, rnd_row());
    step(); step();
    compare_writes();
    check("load_done_sampleReady", sampleReady, 1);
    check("load_done_cfgReady", cfgReady, 0);
  endtask

  task automatic accept_sample(input logic [SW-1:0] data);
    int n;
    sampleValid = 1'b1; sampleData = data;
    n = 0;
    while (!sampleReady && n < 50) begin step(); n++; end
    check("sample_ready_wait", sampleReady, 1);
    step();
    sampleValid = 1'b0; sampleData = SW'($urandom());
    check("send_inputsReady", l2.inputsReady, 1);
    check("send_layer2Input", l2.layer2Input, data);
    check("send_sampleReady", sampleReady, 0);
  endtask

  // Full sample round trip through the Layer2 responder.
  task automatic run_sample(input logic [SW-1:0] data, input int recvDly,
                            input int outDly, input logic [3:0] pred, input int hold);
    accept_sample(data);
    repeat (recvDly) begin
      step();
      check("send_hold_inputsReady", l2.inputsReady, 1);
      check("send_hold_layer2Input", l2.layer2Input, data);
    end
    l2.inputsRecieved = 1'b1;
    step();
    l2.inputsRecieved = 1'b0;
    check("recv_inputsReady", l2.inputsReady, 0);
    repeat (outDly) begin
      step();
      check("wait_outputsRecieved", l2.outputsRecieved, 0);
      check("wait_resultValid", resultValid, 0);
    end
    l2.outputsReady = 1'b1; l2.predictionOutput = pred;
    step();
    l2.outputsReady = 1'b0; l2.predictionOutput = ~pred;
    check("ack_outputsRecieved", l2.outputsRecieved, 1);
    check("result_valid", resultValid, 1);
    check("result_data", resultData, pred);
    step();
    check("ack_one_cycle", l2.outputsRecieved, 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_resultValid", resultValid, 1);
      check("hold_resultData", resultData, pred);
      check("hold_sampleReady", sampleReady, 0);
      step();
    end
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    check("accept_resultValid", resultValid, 0);
    check("accept_sampleReady", sampleReady, 1);
  endtask

  initial begin
    int n;
    l2.inputsRecieved = 1'b0; l2.outputsReady = 1'b0; l2.predictionOutput = '0;

    // Reset state.
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    check("post_reset_cfgReady", cfgReady, 1);
    check("post_reset_sampleReady", sampleReady, 0);

    // Clean load with the documented first row.
    load_all(0, 40'h3C796E06F5);
    check("clean_cfgError", cfgError, 0);

    // Directed sample round trip, then randomized ones.
    run_sample(16'h4306, 3, 5, 4'd7, 6);
    for (int k = 0; k < 4; k++)
      run_sample(SW'($urandom()), $urandom_range(0, 6), $urandom_range(0, 6),
                 4'($urandom()), $urandom_range(0, 4));

    // Layer2 handshakes outside SEND/WAIT_OUT are ignored.
    l2.inputsRecieved = 1'b1; l2.outputsReady = 1'b1;
    repeat (3) step();
    l2.inputsRecieved = 1'b0; l2.outputsReady = 1'b0;
    check("idle_ignore_outputsRecieved", l2.outputsRecieved, 0);
    check("idle_ignore_resultValid", resultValid, 0);
    check("idle_ignore_sampleReady", sampleReady, 1);

    // Watchdog: Layer2 never takes the sample.
    accept_sample(SW'($urandom()));
    n = 0;
    while (!timeoutError && n < 400) begin step(); n++; end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_inputsReady", l2.inputsReady, 0);
    check("timeout_sampleReady", sampleReady, 1);
    check("timeout_resultValid", resultValid, 0);

    // Reload request beats a simultaneous sample.
    sampleValid = 1'b1; sampleData = SW'($urandom()); reloadRequest = 1'b1;
    #1;
    check("reload_sampleReady_forced", sampleReady, 0);
    step();
    sampleValid = 1'b0; reloadRequest = 1'b0;
    check("reload_cfgReady", cfgReady, 1);
    check("reload_inputsReady", l2.inputsReady, 0);
    loaded = 0;

    // Bias row offered during the weight phase.
    load_all(1, rnd_row());
    check("bad_bias_cfgError", cfgError, 1);
    check("sticky_timeoutError", timeoutError, 1);
    run_sample(SW'($urandom()), 1, 2, 4'($urandom()), 1);

    // Asynchronous reset while waiting for the prediction.
    accept_sample(SW'($urandom()));
    l2.inputsRecieved = 1'b1;
    step();
    l2.inputsRecieved = 1'b0;
    step(); step();
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    step();
    obs_q.delete();
    reset = 1'b1;
    loaded = 0; expCfgErr = 1'b0;

    // Fresh load after reset, with a weight row offered in the bias phase.
    load_all(2, rnd_row());
    check("bad_weight_cfgError", cfgError, 1);
    check("fresh_timeoutError", timeoutError, 0);
    run_sample(SW'($urandom()), 2, 1, 4'($urandom()), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
